// File: rtl/frame_pipeline_sequencer.sv
// Frame pipeline sequencer: capture -> core processing -> LeNet inference -> result.
// One frame per pass, per-stage watchdog, sticky timeout flag and wrapping frame counter.
module frame_pipeline_sequencer #(
    parameter int TIMEOUT = 1048576,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run_en,
    input  logic             pause,
    input  logic             capture_end,
    input  logic             core_end,
    input  logic             lenet_ready,
    input  logic [3:0]       lenet_digit,
    output logic             capture_en,
    output logic             core_start,
    output logic             lenet_go,
    output logic [3:0]       digit_out,
    output logic             digit_valid,
    output logic [CNT_W-1:0] frame_count,
    output logic             timeout_err,
    output logic             busy
);

    localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE, CAPTURE, PROCESS, INFER_REQ, INFER_WAIT, DONE
    } state_t;

    state_t           r_state;
    logic [WD_W-1:0]  r_wdog;
    logic             r_accepted;
    logic             r_capture_en;
    logic             r_core_start;
    logic             r_lenet_go;
    logic [3:0]       r_digit_out;
    logic             r_digit_valid;
    logic [CNT_W-1:0] r_frame_count;
    logic             r_timeout_err;
    logic             r_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        state_t v_next;
        logic   v_wd_hit;
        if (!rst_n) begin
            r_state       <= IDLE;
            r_wdog        <= '0;
            r_accepted    <= 1'b0;
            r_capture_en  <= 1'b0;
            r_core_start  <= 1'b0;
            r_lenet_go    <= 1'b0;
            r_digit_out   <= 4'd0;
            r_digit_valid <= 1'b0;
            r_frame_count <= '0;
            r_timeout_err <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            v_next   = r_state;
            v_wd_hit = (r_wdog == WD_LAST);
            r_core_start  <= 1'b0;
            r_lenet_go    <= 1'b0;
            r_digit_valid <= 1'b0;

            // Abort on run_en low wins over end pulses; end pulses win over the watchdog.
            case (r_state)
                IDLE: begin
                    if (run_en && !pause) begin
                        v_next = CAPTURE;
                        r_timeout_err <= 1'b0;
                    end
                end
                CAPTURE: begin
                    if (!run_en) v_next = IDLE;
                    else if (capture_end) begin
                        v_next = PROCESS;
                        r_core_start <= 1'b1;
                    end else if (v_wd_hit) begin
                        v_next = IDLE;
                        r_timeout_err <= 1'b1;
                    end
                end
                PROCESS: begin
                    if (!run_en) v_next = IDLE;
                    else if (core_end) v_next = INFER_REQ;
                    else if (v_wd_hit) begin
                        v_next = IDLE;
                        r_timeout_err <= 1'b1;
                    end
                end
                INFER_REQ: begin
                    if (!run_en) v_next = IDLE;
                    else if (lenet_ready) begin
                        v_next = INFER_WAIT;
                        r_lenet_go <= 1'b1;
                    end else if (v_wd_hit) begin
                        v_next = IDLE;
                        r_timeout_err <= 1'b1;
                    end
                end
                INFER_WAIT: begin
                    // Engine must first drop ready (accept) before a rising ready means done.
                    if (!r_accepted) begin
                        if (!lenet_ready) r_accepted <= 1'b1;
                    end
                    if (r_accepted && lenet_ready) begin
                        v_next = DONE;
                        r_digit_out   <= lenet_digit;
                        r_digit_valid <= 1'b1;
                        r_frame_count <= r_frame_count + 1'b1;
                    end else if (v_wd_hit) begin
                        v_next = IDLE;
                        r_timeout_err <= 1'b1;
                    end
                end
                DONE: begin
                    if (!run_en) v_next = IDLE;
                    else if (!pause) v_next = CAPTURE;
                end
                default: v_next = IDLE;
            endcase

            if (v_next != r_state) begin
                r_wdog <= '0;
                if (v_next == INFER_WAIT) r_accepted <= 1'b0;
            end else if (r_state != IDLE && r_state != DONE) begin
                r_wdog <= r_wdog + 1'b1;
            end

            r_state      <= v_next;
            r_capture_en <= (v_next == CAPTURE);
            r_busy       <= (v_next != IDLE) && (v_next != DONE);
        end
    end

    assign capture_en  = r_capture_en;
    assign core_start  = r_core_start;
    assign lenet_go    = r_lenet_go;
    assign digit_out   = r_digit_out;
    assign digit_valid = r_digit_valid;
    assign frame_count = r_frame_count;
    assign timeout_err = r_timeout_err;
    assign busy        = r_busy;

endmodule

// File: tb/tb_frame_pipeline_sequencer.sv
// Directed bench for frame_pipeline_sequencer: instance A uses default parameters,
// instance B uses TIMEOUT=64 / CNT_W=2 for watchdog and counter-wrap scenarios.
module tb_frame_pipeline_sequencer;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Instance A
    logic       a_run, a_pause, a_cap_end, a_core_end, a_ready;
    logic [3:0] a_digit;
    logic       a_cap_en, a_core_start, a_go, a_dv, a_terr, a_busy;
    logic [3:0] a_dout;
    logic [7:0] a_fcnt;

    // Instance B
    logic       b_run, b_pause, b_cap_end, b_core_end, b_ready;
    logic [3:0] b_digit;
    logic       b_cap_en, b_core_start, b_go, b_dv, b_terr, b_busy;
    logic [3:0] b_dout;
    logic [1:0] b_fcnt;

    frame_pipeline_sequencer dut_a (
        .clk(clk), .rst_n(rst_n), .run_en(a_run), .pause(a_pause),
        .capture_end(a_cap_end), .core_end(a_core_end), .lenet_ready(a_ready),
        .lenet_digit(a_digit), .capture_en(a_cap_en), .core_start(a_core_start),
        .lenet_go(a_go), .digit_out(a_dout), .digit_valid(a_dv),
        .frame_count(a_fcnt), .timeout_err(a_terr), .busy(a_busy)
    );

    frame_pipeline_sequencer #(.TIMEOUT(64), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .run_en(b_run), .pause(b_pause),
        .capture_end(b_cap_end), .core_end(b_core_end), .lenet_ready(b_ready),
        .lenet_digit(b_digit), .capture_en(b_cap_en), .core_start(b_core_start),
        .lenet_go(b_go), .digit_out(b_dout), .digit_valid(b_dv),
        .frame_count(b_fcnt), .timeout_err(b_terr), .busy(b_busy)
    );

    int n_checks = 0;
    int n_err    = 0;
    int cs_a = 0, go_a = 0, dv_a = 0, cap_a = 0;
    int cs_b = 0, go_b = 0, dv_b = 0;

    // Scoreboard entries: {digit[3:0], frame_count[7:0]}
    logic [11:0] qa[$];
    logic [11:0] qb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock, sample 1 time unit later, count pulses and drain the scoreboards.
    task automatic tick();
        logic [11:0] e;
        @(posedge clk);
        #1;
        if (a_core_start) cs_a++;
        if (a_go)         go_a++;
        if (a_cap_en)     cap_a++;
        if (b_core_start) cs_b++;
        if (b_go)         go_b++;
        if (a_dv) begin
            dv_a++;
            chk("a_sb_nonempty", 32'(qa.size() != 0), 1);
            if (qa.size() != 0) begin
                e = qa.pop_front();
                chk("a_digit_out", a_dout, e[11:8]);
                chk("a_frame_count", a_fcnt, e[7:0]);
                $display("A frame done: digit=%0d count=%0d", a_dout, a_fcnt);
            end
        end
        if (b_dv) begin
            dv_b++;
            chk("b_sb_nonempty", 32'(qb.size() != 0), 1);
            if (qb.size() != 0) begin
                e = qb.pop_front();
                chk("b_digit_out", b_dout, e[11:8]);
                chk("b_frame_count", b_fcnt, e[7:0]);
                $display("B frame done: digit=%0d count=%0d", b_dout, b_fcnt);
            end
        end
    endtask

    task automatic b_frame(input logic [3:0] d, input logic [7:0] exp_cnt);
        int k;
        int go0, dv0;
        go0 = go_b;
        dv0 = dv_b;
        b_cap_end = 1'b1; tick(); b_cap_end = 1'b0;
        b_core_end = 1'b1; tick(); b_core_end = 1'b0;
        k = 0;
        while (go_b == go0 && k < 5) begin tick(); k++; end
        chk("b_go_seen", go_b - go0, 1);
        b_ready = 1'b0; tick();
        qb.push_back({d, exp_cnt});
        b_digit = d;
        b_ready = 1'b1;
        k = 0;
        while (dv_b == dv0 && k < 5) begin tick(); k++; end
        chk("b_dv_seen", dv_b - dv0, 1);
        tick();
    endtask

    initial begin
        int k;
        rst_n = 1'b0;
        {a_run, a_pause, a_cap_end, a_core_end} = '0;
        {b_run, b_pause, b_cap_end, b_core_end} = '0;
        a_ready = 1'b1; b_ready = 1'b1;
        a_digit = 4'd0; b_digit = 4'd0;
        #12;
        chk("rst_busy",   a_busy, 0);
        chk("rst_cap_en", a_cap_en, 0);
        chk("rst_dout",   a_dout, 0);
        chk("rst_fcnt",   a_fcnt, 0);
        chk("rst_terr",   b_terr, 0);
        rst_n = 1'b1;
        tick(); tick();
        chk("idle_no_run", a_busy, 0);

        // Watchdog: capture_end never arrives on B.
        b_run = 1'b1;
        tick();
        chk("b_capture_entry", b_cap_en, 1);
        repeat (63) tick();
        chk("b_terr_before", b_terr, 0);
        chk("b_busy_before", b_busy, 1);
        tick();
        chk("b_terr_set", b_terr, 1);
        chk("b_idle_after_to", b_busy, 0);
        tick();
        chk("b_restart_cap", b_cap_en, 1);
        chk("b_terr_cleared", b_terr, 0);

        // Counter wrap on B: five frames, count 1,2,3,0,1.
        for (int i = 1; i <= 5; i++) b_frame(4'(i + 2), 8'(i % 4));
        chk("b_frames", dv_b, 5);
        b_run = 1'b0;
        tick();

        // Normal frame on A.
        a_run = 1'b1;
        tick();
        chk("a_capture_entry", a_cap_en, 1);
        chk("a_busy", a_busy, 1);
        repeat (4) tick();
        a_core_end = 1'b1; tick(); a_core_end = 1'b0;
        chk("a_core_end_ignored", a_cap_en, 1);
        repeat (3) tick();
        a_cap_end = 1'b1; tick(); a_cap_end = 1'b0;
        chk("a_core_start_pulse", a_core_start, 1);
        chk("a_cap_en_off", a_cap_en, 0);
        tick();
        chk("a_core_start_one", a_core_start, 0);
        repeat (39) tick();
        a_core_end = 1'b1; tick(); a_core_end = 1'b0;
        k = 0;
        while (go_a == 0 && k < 5) begin tick(); k++; end
        chk("a_go_once", go_a, 1);
        tick(); tick();
        a_ready = 1'b0;
        repeat (100) tick();
        chk("a_no_early_dv", dv_a, 0);
        chk("a_busy_wait", a_busy, 1);
        qa.push_back({4'd7, 8'd1});
        a_digit = 4'd7;
        a_ready = 1'b1;
        a_pause = 1'b1;
        k = 0;
        while (dv_a == 0 && k < 5) begin tick(); k++; end
        chk("a_dv_once", dv_a, 1);
        chk("a_cs_once", cs_a, 1);
        chk("a_go_total", go_a, 1);
        chk("a_done_idle_busy", a_busy, 0);

        // Pause holds DONE.
        cap_a = 0;
        repeat (1000) tick();
        chk("a_pause_no_cap", cap_a, 0);
        chk("a_pause_digit", a_dout, 7);
        chk("a_pause_dv", dv_a, 1);
        a_pause = 1'b0;
        tick();
        chk("a_unpause_cap", a_cap_en, 1);

        // Abort in PROCESS.
        a_cap_end = 1'b1; tick(); a_cap_end = 1'b0;
        chk("a_abort_process", a_busy, 1);
        a_run = 1'b0;
        tick();
        chk("a_abort_idle", a_busy, 0);
        repeat (3) tick();
        a_core_end = 1'b1; tick(); a_core_end = 1'b0;
        repeat (5) tick();
        chk("a_abort_no_go", go_a, 1);
        chk("a_abort_cs", cs_a, 2);
        chk("a_abort_busy", a_busy, 0);

        // Async reset mid INFER_WAIT.
        a_run = 1'b1;
        tick();
        a_cap_end = 1'b1; tick(); a_cap_end = 1'b0;
        a_core_end = 1'b1; tick(); a_core_end = 1'b0;
        k = 0;
        while (go_a == 1 && k < 5) begin tick(); k++; end
        chk("a_go_second", go_a, 2);
        a_ready = 1'b0;
        repeat (3) tick();
        chk("a_wait_busy", a_busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_busy", a_busy, 0);
        chk("ar_dout", a_dout, 0);
        chk("ar_fcnt", a_fcnt, 0);
        chk("ar_cap_en", a_cap_en, 0);
        chk("ar_pulses", {a_core_start, a_go, a_dv, a_terr}, 0);
        a_run = 1'b0;
        a_digit = 4'd9;
        a_ready = 1'b1;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (4) tick();
        chk("ar_no_dv", dv_a, 1);
        chk("ar_idle", a_busy, 0);

        chk("a_sb_drained", qa.size(), 0);
        chk("b_sb_drained", qb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
